lcd_frame_sequencer: RTL and testbench

Frame-refresh controller for the SPI display path. On a start pulse it emits the display window setup sequence (column address set, page address set, memory write) and then streams every pixel of the frame buffer RAM as 9-bit command/data words into the SPI transmit buffer. Each word carries a mode bit in bit 8 and a byte in bits 7:0, over a valid/ready handshake. It is the only writer of that buffer during a refresh.

---
 rtl/lcd_frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - frame refresh sequencer: window setup words, then every pixel
// of the frame buffer as two 9-bit data words over a valid/ready handshake.
module lcd_frame_sequencer #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_RAM_addr,
  output logic              o_RAM_rd,
  input  logic [15:0]       i_RAM_data,
  output logic [8:0]        o_Data,
  output logic              o_valid,
  input  logic              i_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_FETCH, S_WAIT, S_PIX_HI, S_PIX_LO, S_DONE
  } state_t;

  localparam logic [15:0]       COL_LAST = 16'(WIDTH - 1);
  localparam logic [15:0]       ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            state_q, state_d;
  logic [3:0]        seq_q, seq_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       pix_q, pix_d;
  logic [8:0]        seq_word;
  logic              xfer;

  assign xfer = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_d   = pix_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SEND;
          seq_d   = '0;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (seq_q == 4'd10) state_d = S_FETCH;
          else                seq_d   = seq_q + 4'd1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        pix_d   = i_RAM_data;
        state_d = S_PIX_HI;
      end
      S_PIX_HI: begin
        if (xfer) state_d = S_PIX_LO;
      end
      S_PIX_LO: begin
        if (xfer) begin
          if (addr_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            // Address is a running index; col/row follow the raster position alongside it.
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 16'd1;
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (seq_q)
      4'd0:    seq_word = 9'h02A;
      4'd3:    seq_word = {1'b1, COL_LAST[15:8]};
      4'd4:    seq_word = {1'b1, COL_LAST[7:0]};
      4'd5:    seq_word = 9'h02B;
      4'd8:    seq_word = {1'b1, ROW_LAST[15:8]};
      4'd9:    seq_word = {1'b1, ROW_LAST[7:0]};
      4'd10:   seq_word = 9'h02C;
      default: seq_word = 9'h100;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_RAM_rd   = 1'b0;
    o_valid    = 1'b0;
    o_Data     = '0;
    o_RAM_addr = addr_q;
    unique case (state_q)
      S_SEND: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_Data  = seq_word;
      end
      S_FETCH: begin
        o_busy   = 1'b1;
        o_RAM_rd = 1'b1;
      end
      S_WAIT: o_busy = 1'b1;
      S_PIX_HI: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_Data  = {1'b1, pix_q[15:8]};
      end
      S_PIX_LO: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_Data  = {1'b1, pix_q[7:0]};
      end
      S_DONE:  o_done = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - scoreboard bench for lcd_frame_sequencer
`timescale 1ns/1ps
module tb_lcd_frame_sequencer;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int AW  = 3;
  localparam int LW  = 320;
  localparam int LH  = 240;
  localparam int LAW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, i_start, i_ready;
  logic          o_busy, o_done, o_RAM_rd, o_valid;
  logic [AW-1:0] o_RAM_addr;
  logic [15:0]   ram_data;
  logic [8:0]    o_Data;

  logic           l_start, l_ready, l_busy, l_done, l_rd, l_valid;
  logic [LAW-1:0] l_addr;
  logic [15:0]    l_ram;
  logic [8:0]     l_data;

  lcd_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_RAM_addr(o_RAM_addr), .o_RAM_rd(o_RAM_rd), .i_RAM_data(ram_data),
    .o_Data(o_Data), .o_valid(o_valid), .i_ready(i_ready)
  );

  lcd_frame_sequencer #(.WIDTH(LW), .HEIGHT(LH), .ADDR_W(LAW)) dut_l (
    .clk(clk), .reset_n(reset_n), .i_start(l_start), .o_busy(l_busy), .o_done(l_done),
    .o_RAM_addr(l_addr), .o_RAM_rd(l_rd), .i_RAM_data(l_ram),
    .o_Data(l_data), .o_valid(l_valid), .i_ready(l_ready)
  );

  int         checks = 0, errors = 0;
  int         cyc = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0;
  bit         rand_mode = 1'b0, l_chk_en = 1'b0, stall_prev = 1'b0;
  logic [8:0] stall_data;
  logic [8:0] exp_q[$];
  logic [8:0] exp_l[$];
  int         exp_a[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: one-cycle read latency, contents 0x1000 + address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_RAM_rd) ram_data <= 16'h1000 + 16'(o_RAM_addr);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) i_ready = ($urandom_range(0, 99) < 30);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {o_valid, o_Data}, {1'b1, stall_data});
      if (o_valid) begin
        chk("valid_while_busy", o_busy, 1);
        if (i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got 0x%0h expected none", o_Data);
          end else begin
            chk("word", o_Data, exp_q.pop_front());
          end
        end
        stall_prev = !i_ready;
        stall_data = o_Data;
      end else begin
        stall_prev = 1'b0;
      end
      if (o_RAM_rd) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: got addr %0d expected none", o_RAM_addr);
        end else begin
          chk("ram_addr", o_RAM_addr, exp_a.pop_front());
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && l_chk_en && l_valid && l_ready && exp_l.size() != 0)
      chk("large_setup_word", l_data, exp_l.pop_front());
  end

  function automatic logic [8:0] setup_word(input int i, input int w, input int h);
    logic [15:0] we, he;
    we = 16'(w - 1);
    he = 16'(h - 1);
    case (i)
      0:       return 9'h02A;
      3:       return {1'b1, we[15:8]};
      4:       return {1'b1, we[7:0]};
      5:       return 9'h02B;
      8:       return {1'b1, he[15:8]};
      9:       return {1'b1, he[7:0]};
      10:      return 9'h02C;
      default: return 9'h100;
    endcase
  endfunction

  task automatic push_frame();
    logic [15:0] px;
    for (int i = 0; i < 11; i++) exp_q.push_back(setup_word(i, W, H));
    for (int p = 0; p < W * H; p++) begin
      px = 16'h1000 + 16'(p);
      exp_q.push_back({1'b1, px[15:8]});
      exp_q.push_back({1'b1, px[7:0]});
      exp_a.push_back(p);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
    chk({tag, "_rd"},    o_RAM_rd, 0);
    chk({tag, "_addr"},  o_RAM_addr, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"},  o_Data, 0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_frame(input bit rand_rdy, input bit extra_starts);
    int d0, n;
    bit got;
    push_frame();
    rand_mode = rand_rdy;
    if (!rand_rdy) i_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    first_cyc = cyc;
    if (extra_starts) begin
      repeat (6) @(posedge clk);
      #1;
      pulse_start();
      repeat (15) @(posedge clk);
      #1;
      pulse_start();
    end
    n = 0;
    got = 1'b0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (extra_starts) begin
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    rand_mode = 1'b0;
    i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("words_left", exp_q.size(), 0);
    chk("reads_left", exp_a.size(), 0);
    chk("idle_busy", o_busy, 0);
    if (!rand_rdy) chk("done_latency", done_cyc - first_cyc, 43);
  endtask

  task automatic reset_mid_frame();
    int n;
    push_frame();
    i_ready = 1'b1;
    pulse_start();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(o_RAM_rd && o_RAM_addr == 3) && n < 500);
    chk("reach_pixel3", (n < 500) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("pix3_lo_word", o_Data, 9'h103);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle("midreset");
    reset_n = 1'b1;
    exp_q.delete();
    exp_a.delete();
    i_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic large_setup();
    logic [8:0] lw[11];
    int n;
    lw = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};
    for (int i = 0; i < 11; i++) exp_l.push_back(lw[i]);
    l_chk_en = 1'b1;
    l_start = 1'b1;
    @(posedge clk);
    #1;
    l_start = 1'b0;
    n = 0;
    while (exp_l.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    l_chk_en = 1'b0;
    chk("large_words_left", exp_l.size(), 0);
    chk("large_first_read", {l_rd, 15'd0, l_addr}, {1'b1, 15'd0, 17'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b1;
    l_start = 1'b0;
    l_ready = 1'b1;
    l_ram   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    reset_mid_frame();
    run_frame(1'b0, 1'b0);
    large_setup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
